// File: rtl/conv_channel_adder_param.sv
// Input-channel accumulator: sums CHANNEL_NUM_IN partial planes per output plane,
// then adds a per-output-channel bias, applies optional ReLU and saturates.
module conv_channel_adder_param #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned IMAGE_SIZE      = 612*612,
    parameter int unsigned CHANNEL_NUM_IN  = 64,
    parameter int unsigned CHANNEL_NUM_OUT = 64,
    parameter int unsigned ACC_WIDTH       = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  relu_en,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int unsigned PIX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned IC_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
    localparam int unsigned OC_W  = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [IC_W-1:0]  IC_LAST  = IC_W'(CHANNEL_NUM_IN - 1);
    localparam logic [OC_W-1:0]  OC_LAST  = OC_W'(CHANNEL_NUM_OUT - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [IC_W-1:0]       ic_cnt_q, ic_cnt_d;
    logic [OC_W-1:0]       oc_cnt_q, oc_cnt_d;
    logic [OC_W-1:0]       bwr_ptr_q, bwr_ptr_d;
    logic [DATA_WIDTH-1:0] bias_q [CHANNEL_NUM_OUT];
    logic [DATA_WIDTH-1:0] bias_d [CHANNEL_NUM_OUT];

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_first_q, s1_first_d;
    logic                  s1_last_q, s1_last_d;
    logic                  s1_fend_q, s1_fend_d;
    logic [PIX_W-1:0]      s1_pix_q, s1_pix_d;
    logic [OC_W-1:0]       s1_oc_q, s1_oc_d;
    logic [DATA_WIDTH-1:0] s1_pxl_q, s1_pxl_d;

    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic [ACC_WIDTH-1:0]        ram_mem [IMAGE_SIZE];
    logic [ACC_WIDTH-1:0]        ram_rdata;
    logic                        ram_we_c;
    logic signed [ACC_WIDTH-1:0] acc_c;
    logic signed [SUM_W-1:0]     sum_c;
    logic signed [SUM_W-1:0]     act_c;
    logic signed [SUM_W-1:0]     sat_c;

    // Partial-sum RAM: synchronous read in S1, write-back in S2.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram_mem[s1_pix_q] <= acc_c;
        end
        if (valid_in) begin
            ram_rdata <= ram_mem[pix_cnt_q];
        end
    end

    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        ic_cnt_d     = ic_cnt_q;
        oc_cnt_d     = oc_cnt_q;
        bwr_ptr_d    = bwr_ptr_q;
        bias_d       = bias_q;
        s1_valid_d   = valid_in;
        s1_first_d   = s1_first_q;
        s1_last_d    = s1_last_q;
        s1_fend_d    = s1_fend_q;
        s1_pix_d     = s1_pix_q;
        s1_oc_d      = s1_oc_q;
        s1_pxl_d     = s1_pxl_q;
        pxl_out_d    = pxl_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;

        // S2: accumulate, write back non-final planes, finish final plane.
        acc_c    = s1_first_q ? ACC_WIDTH'($signed(s1_pxl_q))
                              : $signed(ram_rdata) + ACC_WIDTH'($signed(s1_pxl_q));
        ram_we_c = s1_valid_q && !s1_last_q;
        sum_c    = SUM_W'(acc_c) + SUM_W'($signed(bias_q[s1_oc_q]));
        act_c    = (relu_en && sum_c[SUM_W-1]) ? '0 : sum_c;
        if (act_c > SAT_MAX) begin
            sat_c = SAT_MAX;
        end else if (act_c < SAT_MIN) begin
            sat_c = SAT_MIN;
        end else begin
            sat_c = act_c;
        end
        if (s1_valid_q && s1_last_q) begin
            valid_out_d  = 1'b1;
            frame_done_d = s1_fend_q;
            pxl_out_d    = DATA_WIDTH'(sat_c);
        end

        // S1: capture sample and its position, then advance the raster counters.
        if (valid_in) begin
            s1_first_d = (ic_cnt_q == '0);
            s1_last_d  = (ic_cnt_q == IC_LAST);
            s1_fend_d  = (pix_cnt_q == PIX_LAST) && (oc_cnt_q == OC_LAST);
            s1_pix_d   = pix_cnt_q;
            s1_oc_d    = oc_cnt_q;
            s1_pxl_d   = pxl_in;
            if (pix_cnt_q == PIX_LAST) begin
                pix_cnt_d = '0;
                if (ic_cnt_q == IC_LAST) begin
                    ic_cnt_d = '0;
                    oc_cnt_d = (oc_cnt_q == OC_LAST) ? '0 : oc_cnt_q + OC_W'(1);
                end else begin
                    ic_cnt_d = ic_cnt_q + IC_W'(1);
                end
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
        end

        // Bias write lands after this cycle's S2 read, so S2 sees the old value.
        if (valid_bias_in) begin
            bias_d[bwr_ptr_q] = bias_in;
            bwr_ptr_d         = (bwr_ptr_q == OC_LAST) ? '0 : bwr_ptr_q + OC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_q    <= '0;
            ic_cnt_q     <= '0;
            oc_cnt_q     <= '0;
            bwr_ptr_q    <= '0;
            bias_q       <= '{default: '0};
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_fend_q    <= 1'b0;
            s1_pix_q     <= '0;
            s1_oc_q      <= '0;
            s1_pxl_q     <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            ic_cnt_q     <= ic_cnt_d;
            oc_cnt_q     <= oc_cnt_d;
            bwr_ptr_q    <= bwr_ptr_d;
            bias_q       <= bias_d;
            s1_valid_q   <= s1_valid_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            s1_fend_q    <= s1_fend_d;
            s1_pix_q     <= s1_pix_d;
            s1_oc_q      <= s1_oc_d;
            s1_pxl_q     <= s1_pxl_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_channel_adder_param.sv
// Drives three parameterisations of the channel adder from one stream and
// compares every cycle against an integer-arithmetic reference model.
module tb_conv_channel_adder_param;

    localparam int IS   = 4;
    localparam int COUT = 2;

    typedef logic signed [63:0] v64_t;

    logic        clk = 1'b0;
    logic        reset, relu_en, valid_in, valid_bias_in;
    logic [31:0] pxl_in, bias_in;
    logic [31:0] pxl_a, pxl_c;
    logic [7:0]  pxl_b;
    logic        vo_a, vo_b, vo_c, fd_a, fd_b, fd_c;

    always #5 clk = ~clk;

    conv_channel_adder_param #(.DATA_WIDTH(32), .IMAGE_SIZE(IS), .CHANNEL_NUM_IN(3),
                               .CHANNEL_NUM_OUT(COUT)) dut_a (
        .clk(clk), .reset(reset), .relu_en(relu_en), .valid_in(valid_in),
        .pxl_in(pxl_in), .valid_bias_in(valid_bias_in), .bias_in(bias_in),
        .pxl_out(pxl_a), .valid_out(vo_a), .frame_done(fd_a));

    conv_channel_adder_param #(.DATA_WIDTH(8), .IMAGE_SIZE(IS), .CHANNEL_NUM_IN(3),
                               .CHANNEL_NUM_OUT(COUT)) dut_b (
        .clk(clk), .reset(reset), .relu_en(relu_en), .valid_in(valid_in),
        .pxl_in(pxl_in[7:0]), .valid_bias_in(valid_bias_in), .bias_in(bias_in[7:0]),
        .pxl_out(pxl_b), .valid_out(vo_b), .frame_done(fd_b));

    conv_channel_adder_param #(.DATA_WIDTH(32), .IMAGE_SIZE(IS), .CHANNEL_NUM_IN(1),
                               .CHANNEL_NUM_OUT(COUT)) dut_c (
        .clk(clk), .reset(reset), .relu_en(relu_en), .valid_in(valid_in),
        .pxl_in(pxl_in), .valid_bias_in(valid_bias_in), .bias_in(bias_in),
        .pxl_out(pxl_c), .valid_out(vo_c), .frame_done(fd_c));

    // Reference model state, one slot per instance (a, b, c).
    int     cfg_dw  [3] = '{32, 8, 32};
    int     cfg_cin [3] = '{3, 3, 1};
    int     m_pix [3], m_ic [3], m_oc [3], m_bwr [3];
    longint m_sum [3][IS];
    longint m_bias [3][COUT];
    bit     pend_v [3], pend_fd [3];
    longint pend_val [3];

    int   checks = 0;
    int   failures = 0;
    int   fdn [3];
    v64_t rec_a [$], rec_b [$], rec_c [$], cont [$];
    logic [31:0] rdata [72];
    logic [31:0] rb0, rb1;

    function automatic longint sx(longint v, int dw);
        longint t = v << (64 - dw);
        return t >>> (64 - dw);
    endfunction

    function automatic longint clamp(longint s, int dw);
        longint lim = longint'(1) << (dw - 1);
        if (s > lim - 1) return lim - 1;
        if (s < -lim) return -lim;
        return s;
    endfunction

    task automatic chk(string tag, v64_t obs, v64_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(string tag, int which, int idx, v64_t exp);
        v64_t obs = 'x;
        case (which)
            0: if (idx < rec_a.size()) obs = rec_a[idx];
            1: if (idx < rec_b.size()) obs = rec_b[idx];
            default: if (idx < rec_c.size()) obs = rec_c[idx];
        endcase
        chk($sformatf("%s[%0d]", tag, idx), obs, exp);
    endtask

    task automatic clr();
        rec_a.delete();
        rec_b.delete();
        rec_c.delete();
        fdn = '{0, 0, 0};
    endtask

    // One clock: apply inputs, advance the model, then check what the DUTs show.
    task automatic step(bit rst, bit vin, logic [31:0] px, bit vb, logic [31:0] b);
        bit     nv [3], nfd [3], ov [3], ofd [3];
        longint nval [3];
        v64_t   opx [3];
        longint x, s;
        reset = rst; valid_in = vin; pxl_in = px; valid_bias_in = vb; bias_in = b;
        for (int d = 0; d < 3; d++) begin
            nv[d] = 0; nfd[d] = 0; nval[d] = 0;
            if (rst) begin
                m_pix[d] = 0; m_ic[d] = 0; m_oc[d] = 0; m_bwr[d] = 0;
                for (int k = 0; k < COUT; k++) m_bias[d][k] = 0;
            end else begin
                if (vin) begin
                    x = sx(longint'(px), cfg_dw[d]);
                    if (m_ic[d] == 0) m_sum[d][m_pix[d]] = x;
                    else m_sum[d][m_pix[d]] += x;
                    if (m_ic[d] == cfg_cin[d] - 1) begin
                        s = m_sum[d][m_pix[d]] + m_bias[d][m_oc[d]];
                        if (relu_en && s < 0) s = 0;
                        nval[d] = clamp(s, cfg_dw[d]);
                        nv[d]   = 1;
                        nfd[d]  = (m_pix[d] == IS - 1) && (m_oc[d] == COUT - 1);
                    end
                    m_pix[d]++;
                    if (m_pix[d] == IS) begin
                        m_pix[d] = 0;
                        m_ic[d]++;
                        if (m_ic[d] == cfg_cin[d]) begin
                            m_ic[d] = 0;
                            m_oc[d] = (m_oc[d] + 1) % COUT;
                        end
                    end
                end
                if (vb) begin
                    m_bias[d][m_bwr[d]] = sx(longint'(b), cfg_dw[d]);
                    m_bwr[d] = (m_bwr[d] + 1) % COUT;
                end
            end
        end
        @(posedge clk);
        #1;
        ov  = '{vo_a, vo_b, vo_c};
        ofd = '{fd_a, fd_b, fd_c};
        opx[0] = 64'($signed(pxl_a));
        opx[1] = 64'($signed(pxl_b));
        opx[2] = 64'($signed(pxl_c));
        for (int d = 0; d < 3; d++) begin
            bit     cv  = rst ? 1'b0 : pend_v[d];
            bit     cfd = rst ? 1'b0 : pend_fd[d];
            longint cval = pend_val[d];
            pend_v[d]   = rst ? 1'b0 : nv[d];
            pend_fd[d]  = rst ? 1'b0 : nfd[d];
            pend_val[d] = nval[d];
            chk($sformatf("valid_out%0d", d), 64'(ov[d]), 64'(cv));
            chk($sformatf("frame_done%0d", d), 64'(ofd[d]), 64'(cfd));
            if (cv) chk($sformatf("pxl_out%0d", d), opx[d], cval);
            if (rst) chk($sformatf("rst_pxl_out%0d", d), opx[d], 0);
            if (ov[d] === 1'b1) begin
                case (d)
                    0: rec_a.push_back(opx[d]);
                    1: rec_b.push_back(opx[d]);
                    default: rec_c.push_back(opx[d]);
                endcase
            end
            if (ofd[d] === 1'b1) fdn[d]++;
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic load_bias(logic [31:0] b0, logic [31:0] b1);
        step(0, 0, 0, 1, b0);
        step(0, 0, 0, 1, b1);
    endtask

    // One frame for the 3-plane instances: planes a, b, c for each output channel.
    task automatic frame3(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        for (int oc = 0; oc < COUT; oc++)
            for (int p = 0; p < 3; p++)
                for (int px = 0; px < IS; px++)
                    step(0, 1, (p == 0) ? a : (p == 1) ? b : c, 0, 0);
    endtask

    initial begin
        relu_en = 0;
        for (int d = 0; d < 3; d++) begin
            pend_v[d] = 0; pend_fd[d] = 0; pend_val[d] = 0;
        end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(1);

        // Basic sums with biases {10,-5}.
        clr();
        load_bias(32'd10, 32'(-5));
        frame3(32'd1, 32'd2, 32'd3);
        idle(3);
        chk("basic_count", 64'(rec_a.size()), 8);
        for (int i = 0; i < 8; i++) chk_rec("basic", 0, i, (i < 4) ? 16 : 1);
        chk("basic_fd", 64'(fdn[0]), 1);

        // ReLU on and off with inputs -7.
        clr();
        load_bias(0, 0);
        relu_en = 1;
        frame3(32'(-7), 32'(-7), 32'(-7));
        idle(3);
        for (int i = 0; i < 8; i++) chk_rec("relu_on", 0, i, 0);
        clr();
        relu_en = 0;
        frame3(32'(-7), 32'(-7), 32'(-7));
        idle(3);
        for (int i = 0; i < 8; i++) chk_rec("relu_off", 0, i, -21);

        // 8-bit saturation at both ends.
        clr();
        load_bias(32'd127, 32'd127);
        frame3(32'd127, 32'd127, 32'd127);
        idle(3);
        for (int i = 0; i < 8; i++) chk_rec("sat_hi", 1, i, 127);
        chk("sat_hi_a", rec_a.size() > 0 ? rec_a[0] : 'x, 508);
        clr();
        load_bias(32'(-128), 32'(-128));
        frame3(32'(-128), 32'(-128), 32'(-128));
        idle(3);
        for (int i = 0; i < 8; i++) chk_rec("sat_lo", 1, i, -128);

        // Random data: continuous stream vs gapped stream, three frames each.
        for (int i = 0; i < 72; i++) rdata[i] = $urandom;
        rb0 = $urandom;
        rb1 = $urandom;
        clr();
        load_bias(rb0, rb1);
        for (int i = 0; i < 72; i++) step(0, 1, rdata[i], 0, 0);
        idle(3);
        cont = rec_a;
        chk("cont_fd", 64'(fdn[0]), 3);
        clr();
        load_bias(rb0, rb1);
        for (int i = 0; i < 72; i++) begin
            while ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0);
            step(0, 1, rdata[i], 0, 0);
        end
        idle(3);
        chk("gap_fd", 64'(fdn[0]), 3);
        chk("gap_count", 64'(rec_a.size()), 64'(cont.size()));
        for (int i = 0; i < cont.size(); i++) chk_rec("gap_vs_cont", 0, i, cont[i]);

        // Single input channel: out = pxl_in + bias.
        step(1, 0, 0, 0, 0);
        clr();
        load_bias(32'd100, 32'd100);
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i), 0, 0);
        idle(3);
        chk("cin1_count", 64'(rec_c.size()), 4);
        for (int i = 0; i < 4; i++) chk_rec("cin1", 2, i, 100 + i);

        // Reset during the second plane, then a fresh frame with cleared biases.
        load_bias(32'd50, 32'd60);
        for (int i = 0; i < 6; i++) step(0, 1, 32'd5, 0, 0);
        step(1, 1, 32'd9, 0, 0);
        step(1, 1, 32'd9, 0, 0);
        clr();
        frame3(32'd1, 32'd2, 32'd3);
        idle(3);
        chk("rst_count", 64'(rec_a.size()), 8);
        for (int i = 0; i < 8; i++) chk_rec("after_rst", 0, i, 6);
        chk("rst_fd", 64'(fdn[0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_channel_adder_param.md
# conv_channel_adder_param

Parametrised input-channel accumulator for the 3x3 conv pipeline. It sits directly after the conv core (3x3 dilation engine) and sums per-input-channel partial planes into one output plane per output channel. It generalises the fixed 64-channel adder to any input/output channel count and image size, and adds per-output-channel bias, optional ReLU and output saturation. It also provides a frame-done pulse.

## Interface
- DATA_WIDTH, 32: signed two's-complement sample width (in, bias, out)
- IMAGE_SIZE, 612*612: pixels per plane; partial-sum RAM depth; must be >= 4
- CHANNEL_NUM_IN, 64: partial planes summed per output plane; >= 1
- CHANNEL_NUM_OUT, 64: output planes per frame; bias table depth
- ACC_WIDTH, DATA_WIDTH+$clog2(CHANNEL_NUM_IN)+1: internal accumulator/RAM width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- relu_en  in  1  quasi-static; 1 = clamp negative outputs to 0
- valid_in  in  1  pxl_in qualifier
- pxl_in  in  DATA_WIDTH  partial conv result
- valid_bias_in  in  1  bias_in qualifier
- bias_in  in  DATA_WIDTH  bias for next output channel slot
- pxl_out  out  DATA_WIDTH  summed, biased, activated, saturated pixel
- valid_out  out  1  pxl_out qualifier
- frame_done  out  1  one-cycle pulse with last valid_out of a frame

## Operation
- Input order: output channel (outer), input channel, pixel (inner, raster, IMAGE_SIZE per plane). Gaps in valid_in are allowed anywhere; there is no backpressure.
- Counters pix_cnt (0..IMAGE_SIZE-1), ic_cnt (0..CHANNEL_NUM_IN-1) and oc_cnt (0..CHANNEL_NUM_OUT-1) advance only on valid_in. pix_cnt wrap increments ic_cnt. ic_cnt wrap increments oc_cnt. oc_cnt wrap returns to 0 and starts a new frame with no idle cycle needed.
- Plane type is decided by ic_cnt:
  - FIRST (ic_cnt==0): acc = sext(pxl_in); RAM[pix_cnt] <= acc.
  - MID: acc = RAM[pix_cnt] + sext(pxl_in); written back.
  - LAST (ic_cnt==CHANNEL_NUM_IN-1): acc computed as for MID, not written; result emitted.
  - If CHANNEL_NUM_IN==1, every plane is both FIRST and LAST: out = pxl_in + bias.
- Output on LAST: s = acc + sext(bias[oc_cnt]). If relu_en and s<0, s = 0. Saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Bias table: CHANNEL_NUM_OUT x DATA_WIDTH registers, reset to 0. Each valid_bias_in writes bias[bwr_ptr]; bwr_ptr increments and wraps at CHANNEL_NUM_OUT. Loads may overlap streaming. A bias is used only if written before the first pixel of that channel's LAST plane; otherwise the behaviour is undefined.
- The RAM is synchronous-read, single write port. Read and write addresses of the same pixel are IMAGE_SIZE samples apart, so no forwarding is required.

## Timing
- Pipeline, 2 stages:
  - S1 (cycle of valid_in): RAM read issued at pix_cnt; pxl_in, plane type, oc_cnt and valid registered.
  - S2: add, RAM write-back (FIRST/MID), bias/ReLU/saturate into output register.
- Latency: valid_in in cycle t on a LAST plane gives valid_out in t+2. valid_out is never asserted for FIRST/MID planes.
- Throughput: 1 pixel/clock sustained.
- frame_done is asserted with valid_out for pixel IMAGE_SIZE-1 of oc_cnt==CHANNEL_NUM_OUT-1.
- Reset values: pxl_out=0, valid_out=0, frame_done=0; all counters 0, bwr_ptr 0, bias table 0. RAM contents are don't-care because a FIRST plane always overwrites them.
- Reset mid-frame: in-flight S1/S2 data is dropped, with no valid_out the cycle after reset. The next valid_in is treated as pixel 0, input channel 0, output channel 0.
- Simultaneous valid_bias_in and valid_in: both are accepted. If the write targets the bias being read in S2 the same cycle, the old value is used.

## Test plan
- IMAGE_SIZE=4, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2, biases {10,-5}. Planes are all 1, all 2, all 3 for each oc.
  - Expected: valid_out 4 pixels of 16, then 4 of 1, each 2 cycles after the LAST input.
  - frame_done on the 8th output.
- Same config with relu_en=1, inputs -7 each, bias 0.
  - Expected: out=0.
  - With relu_en=0, expected out=-21.
- DATA_WIDTH=8, inputs 127 x 3 planes, bias 127.
  - Expected: out saturates to 127.
  - Inputs -128 x 3, bias -128: out=-128.
- Random valid_in gaps (50% duty) vs continuous stream with identical data.
  - Expected: identical pxl_out sequence, and frame_done count = 1 per frame, over 3 back-to-back frames.
- CHANNEL_NUM_IN=1, inputs 0..3, bias 100.
  - Expected: outputs 100..103, 2-cycle latency.
- Reset asserted during the second input plane, then a full fresh frame.
  - Expected: no valid_out during or right after reset; fresh frame results exact; bias table reads 0 unless reloaded.
